// File: rtl/tpu_gen2.sv
// tpu_gen2: text processing unit. Executes 48-bit commands against a dual-port
// text RAM: clear, print, locate, set attribute, set mask, scroll-up and fill.
// Optional feature macro: TPU_AUTOSCROLL_EN (a PRINT that runs off the bottom
// row scrolls the screen by the glyph height instead of wrapping to row 0).
// Outputs are decoded from registered state; during a scroll copy the write
// data is the RAM read data passed straight through.
module tpu_gen2 #(
  parameter int COLS     = 100,
  parameter int ROWS     = 60,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              execute,
  input  logic [47:0]       command,
  output logic              busy,
  output logic              video_write,
  output logic              video_read,
  output logic [ADDR_W-1:0] video_address,
  output logic [23:0]       video_value,
  input  logic [23:0]       video_rdata,
  output logic [23:0]       video_mask
);
  typedef enum logic [3:0] {
    IDLE, CLR, PR_CELL, PR_ADV, SCR_RD, SCR_WAIT, SCR_WR, SCR_BLANK, FILL, DONE
  } state_t;

  typedef struct packed {
    logic       inv;
    logic       ul;
    logic [2:0] bg;
    logic [2:0] fg;
    logic       blink;
    logic [1:0] size;
    logic       ht;
    logic [1:0] page;
  } attr_t;

  localparam attr_t             ATTR_RST = '{1'b0, 1'b0, 3'd0, 3'd7, 1'b0, 2'd0, 1'b0, 2'd0};
  localparam logic [ADDR_W-1:0] TOTAL    = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] TOTAL_M1 = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [8:0]        COLS9    = 9'(COLS);
  localparam logic [8:0]        ROWS9    = 9'(ROWS);
  localparam logic [7:0]        XMAX     = 8'(COLS - 1);
  localparam logic [7:0]        YMAX     = 8'(ROWS - 1);
  localparam logic [2:0]        WL       = 3'(READ_LAT - 1);

  state_t            state_q, state_d;
  attr_t             attr_q, attr_d;
  logic [7:0]        x_q, x_d, y_q, y_d, ch_q, ch_d;
  logic [23:0]       mask_q, mask_d;
  logic [1:0]        ci_q, ci_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, off_q, off_d, cend_q, cend_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [7:0]        fx0_q, fx0_d, fx_q, fx_d, fy_q, fy_d;
  logic [8:0]        fxe_q, fxe_d, fye_q, fye_d;

  // Combinational helpers: glyph geometry, cell coordinates, clip bounds.
  logic [7:0]        gw, gh, scr_n;
  logic [8:0]        nx, ny, cx, cy, sx, sy, nfx, nfy;
  logic              cell_on, scr_go;
  logic [ADDR_W-1:0] cell_addr, fill_addr, off_n;
  logic [23:0]       cell_val, fill_val, blank_val;

  always_comb begin
    gw        = {7'd0, attr_q.size[0]} + 8'd1;
    gh        = {7'd0, attr_q.size[1]} + 8'd1;
    nx        = {1'b0, x_q} + {1'b0, gw};
    ny        = {1'b0, y_q} + {1'b0, gh};
    cx        = {1'b0, x_q} + {8'd0, ci_q[0]};
    cy        = {1'b0, y_q} + {8'd0, ci_q[1]};
    cell_on   = (cx < COLS9) && (cy < ROWS9);
    cell_addr = ADDR_W'(cy) * COLS_A + ADDR_W'(cx);
    fill_addr = ADDR_W'(fy_q) * COLS_A + ADDR_W'(fx_q);
    sx        = {1'b0, command[15:8]} + {1'b0, command[31:24]};
    sy        = {1'b0, command[23:16]} + {1'b0, command[39:32]};
    nfx       = {1'b0, fx_q} + 9'd1;
    nfy       = {1'b0, fy_q} + 9'd1;
    cell_val  = {attr_q.inv, attr_q.ul, attr_q.bg, attr_q.fg, attr_q.blink, ci_q,
                 attr_q.size, attr_q.ht, attr_q.page, ch_q};
    fill_val  = {attr_q.inv, attr_q.ul, attr_q.bg, attr_q.fg, attr_q.blink, 2'b00,
                 attr_q.size, attr_q.ht, attr_q.page, ch_q};
    blank_val = {2'b00, attr_q.bg, attr_q.fg, 8'h00, 8'h20};
  end

  // State and working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;      attr_q <= ATTR_RST;  x_q <= '0;    y_q <= '0;
      ch_q    <= '0;        mask_q <= 24'hFFFFFF; ci_q <= '0;  cnt_q <= '0;
      off_q   <= '0;        cend_q <= '0;        wcnt_q <= '0; fx0_q <= '0;
      fx_q    <= '0;        fy_q   <= '0;        fxe_q <= '0;  fye_q <= '0;
    end else begin
      state_q <= state_d;   attr_q <= attr_d;    x_q <= x_d;   y_q <= y_d;
      ch_q    <= ch_d;      mask_q <= mask_d;    ci_q <= ci_d; cnt_q <= cnt_d;
      off_q   <= off_d;     cend_q <= cend_d;    wcnt_q <= wcnt_d; fx0_q <= fx0_d;
      fx_q    <= fx_d;      fy_q   <= fy_d;      fxe_q <= fxe_d; fye_q <= fye_d;
    end
  end

  // Next-state: command decode and per-state sequencing.
  always_comb begin
    state_d = state_q; attr_d = attr_q; x_d = x_q; y_d = y_q; ch_d = ch_q;
    mask_d = mask_q; ci_d = ci_q; cnt_d = cnt_q; off_d = off_q; cend_d = cend_q;
    wcnt_d = wcnt_q; fx0_d = fx0_q; fx_d = fx_q; fy_d = fy_q; fxe_d = fxe_q;
    fye_d = fye_q; scr_go = 1'b0; scr_n = 8'd0;
    off_d = off_q;
    case (state_q)
      IDLE: if (execute) begin
        case (command[7:0])
          8'h01: begin state_d = CLR; cnt_d = '0; x_d = '0; y_d = '0; attr_d = ATTR_RST; end
          8'h02: begin state_d = PR_CELL; ch_d = command[15:8]; ci_d = 2'd0; end
          8'h03: begin
            state_d = DONE;
            x_d = (command[15:8] > XMAX) ? XMAX : command[15:8];
            y_d = (command[23:16] > YMAX) ? YMAX : command[23:16];
          end
          8'h04: begin
            state_d = DONE;
            attr_d  = '{command[23], command[22], command[21:19], command[18:16],
                        command[15], command[12:11], command[10], command[9:8]};
          end
          8'h05: begin state_d = DONE; mask_d = command[31:8]; end
          8'h06: begin scr_go = 1'b1; scr_n = command[15:8]; end
          8'h07: begin
            fx0_d = command[15:8]; fx_d = command[15:8]; fy_d = command[23:16];
            ch_d  = command[47:40];
            fxe_d = (sx > COLS9) ? COLS9 : sx;
            fye_d = (sy > ROWS9) ? ROWS9 : sy;
            if (command[31:24] == 8'd0 || command[39:32] == 8'd0 ||
                {1'b0, command[15:8]} >= COLS9 || {1'b0, command[23:16]} >= ROWS9)
              state_d = DONE;
            else
              state_d = FILL;
          end
          default: state_d = IDLE;
        endcase
      end
      CLR: begin
        cnt_d = cnt_q + ONE_A;
        if (cnt_q == TOTAL_M1) state_d = DONE;
      end
      PR_CELL: begin
        if (ci_q == attr_q.size) state_d = PR_ADV;
        else ci_d = ci_q + (attr_q.size[0] ? 2'd1 : 2'd2);
      end
      PR_ADV: begin
        state_d = DONE;
        if (nx >= COLS9) begin
          x_d = '0;
          if (ny >= ROWS9) begin
`ifdef TPU_AUTOSCROLL_EN
            y_d    = 8'(ROWS) - gh;
            scr_go = 1'b1;
            scr_n  = gh;
`else
            y_d = '0;
`endif
          end else begin
            y_d = ny[7:0];
          end
        end else begin
          x_d = nx[7:0];
        end
      end
      SCR_RD: begin
        wcnt_d  = 3'd1;
        state_d = (READ_LAT == 1) ? SCR_WR : SCR_WAIT;
      end
      SCR_WAIT: begin
        if (wcnt_q == WL) state_d = SCR_WR;
        else wcnt_d = wcnt_q + 3'd1;
      end
      SCR_WR: begin
        cnt_d   = cnt_q + ONE_A;
        state_d = (cnt_q == cend_q - ONE_A) ? SCR_BLANK : SCR_RD;
      end
      SCR_BLANK: begin
        cnt_d = cnt_q + ONE_A;
        if (cnt_q == TOTAL_M1) state_d = DONE;
      end
      FILL: begin
        if (nfx >= fxe_q) begin
          fx_d = fx0_q;
          if (nfy >= fye_q) state_d = DONE;
          else fy_d = nfy[7:0];
        end else begin
          fx_d = nfx[7:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Scroll entry is shared by the SCROLL opcode and print autoscroll.
    off_n = ADDR_W'(scr_n) * COLS_A;
    if (scr_go) begin
      cnt_d = '0;
      off_d = off_n;
      if (scr_n == 8'd0) state_d = DONE;
      else if ({1'b0, scr_n} >= ROWS9) state_d = SCR_BLANK;
      else begin state_d = SCR_RD; cend_d = TOTAL - off_n; end
    end
  end

  // Output decode from the current state; reads and writes never overlap.
  always_comb begin
    busy          = (state_q != IDLE);
    video_write   = 1'b0;
    video_read    = 1'b0;
    video_address = '0;
    video_value   = '0;
    video_mask    = 24'hFFFFFF;
    case (state_q)
      CLR:       begin video_write = 1'b1; video_address = cnt_q; video_value = 24'h070020; end
      PR_CELL:   begin
        video_write = cell_on; video_address = cell_addr; video_value = cell_val;
        video_mask  = mask_q;
      end
      SCR_RD:    begin video_read = 1'b1; video_address = cnt_q + off_q; end
      SCR_WR:    begin video_write = 1'b1; video_address = cnt_q; video_value = video_rdata; end
      SCR_BLANK: begin video_write = 1'b1; video_address = cnt_q; video_value = blank_val; end
      FILL:      begin
        video_write = 1'b1; video_address = fill_addr; video_value = fill_val;
        video_mask  = mask_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_tpu_gen2.sv
// Scoreboard bench for tpu_gen2 (100x60 screen, read latency 2).
// Stimulus pushes expected writes; a negedge monitor pops and compares them.
module tb_tpu_gen2;
  localparam int COLS = 100, ROWS = 60, AW = 16, RL = 2;

  logic          clk = 1'b0;
  logic          reset, execute;
  logic [47:0]   command;
  logic          busy, video_write, video_read;
  logic [AW-1:0] video_address;
  logic [23:0]   video_value, video_rdata, video_mask;

  always #5 clk = ~clk;

  tpu_gen2 #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset), .execute(execute), .command(command), .busy(busy),
    .video_write(video_write), .video_read(video_read), .video_address(video_address),
    .video_value(video_value), .video_rdata(video_rdata), .video_mask(video_mask));

  typedef struct packed { logic [15:0] a; logic [23:0] v; logic [23:0] m; } wr_t;
  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks = 0, errors = 0;

  // Text RAM model with a READ_LAT-deep read pipeline.
  logic [23:0] mem [0:5999];
  logic [15:0] rpa [0:1];
  logic        preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 6000; i++) mem[i] <= {8'h07, 8'h00, 8'(i / 100)};
    end else if (video_write && video_address < 16'd6000) begin
      mem[video_address] <= (mem[video_address] & ~video_mask) | (video_value & video_mask);
    end
    rpa[0] <= video_address;
    rpa[1] <= rpa[0];
  end
  assign video_rdata = (rpa[1] < 16'd6000) ? mem[rpa[1]] : 24'h0;

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (video_write && video_read) begin
      checks++; errors++;
      $display("FAIL rw_exclusive: read and write both high at addr %0d", video_address);
    end
    if (video_write) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d value=%06h", video_address, video_value);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (video_address !== mon_e.a || video_value !== mon_e.v || video_mask !== mon_e.m) begin
          errors++;
          $display("FAIL write: got a=%0d v=%06h m=%06h expected a=%0d v=%06h m=%06h",
                   video_address, video_value, video_mask, mon_e.a, mon_e.v, mon_e.m);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [23:0] v, input logic [23:0] m);
    wr_t e;
    e.a = 16'(a); e.v = v; e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [47:0] c);
    @(negedge clk); execute = 1'b1; command = c;
    @(negedge clk); execute = 1'b0;
  endtask

  task automatic wait_idle(output int bc);
    bc = 0;
    while (busy === 1'b1 && bc < 40000) begin bc++; @(negedge clk); end
    if (bc >= 40000) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", bc);
    end
  endtask

  task automatic run(input logic [47:0] c, output int bc);
    send(c);
    wait_idle(bc);
  endtask

  int bc, n;

  initial begin
    reset = 1'b1; execute = 1'b0; command = '0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_write", {31'd0, video_write}, 32'd0);
    chk("rst_read", {31'd0, video_read}, 32'd0);
    chk("rst_addr", {16'd0, video_address}, 32'd0);
    chk("rst_value", {8'd0, video_value}, 32'd0);
    chk("rst_mask", {8'd0, video_mask}, 32'hFFFFFF);
    reset = 1'b0;

    // CLEAR: 6000 blank writes, busy for 6001 cycles.
    for (int i = 0; i < 6000; i++) push(i, 24'h070020, 24'hFFFFFF);
    run(48'h01, bc);
    chk("clear_busy", bc, 32'd6001);
    chk("clear_drained", exp_q.size(), 32'd0);

    // Cursor home after CLEAR.
    push(0, 24'h070031, 24'hFFFFFF);
    run(48'h3102, bc);

    // 2x2 glyph at (98,10), then cursor lands at (0,12).
    run(48'h0000_000A_6203, bc);
    chk("locate_busy", bc, 32'd1);
    run(48'h0000_0007_1804, bc);
    chk("setattr_busy", bc, 32'd1);
    push(1098, 24'h071841, 24'hFFFFFF);
    push(1099, 24'h073841, 24'hFFFFFF);
    push(1198, 24'h075841, 24'hFFFFFF);
    push(1199, 24'h077841, 24'hFFFFFF);
    run(48'h4102, bc);
    run(48'h0000_0007_0004, bc);
    push(1200, 24'h07005A, 24'hFFFFFF);
    run(48'h5A02, bc);

    // Bottom-right cell, then wrap to (0,0).
    run(48'h0000_003B_6303, bc);
    push(5999, 24'h070042, 24'hFFFFFF);
    run(48'h4202, bc);
    push(0, 24'h070043, 24'hFFFFFF);
    run(48'h4302, bc);

    // LOCATE clamps to (99,59).
    run(48'h0000_00C8_C803, bc);
    push(5999, 24'h070044, 24'hFFFFFF);
    run(48'h4402, bc);

    // Mask register applies to PRINT.
    run(48'h0000_00FF_0005, bc);
    run(48'h0000_0005_0503, bc);
    push(505, 24'h070046, 24'h00FF00);
    run(48'h4602, bc);
    run(48'h0000_FFFF_FF05, bc);

    // SCROLL N=2 over preloaded rows (row r holds char r).
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    for (int a = 0; a < 5800; a++) push(a, {8'h07, 8'h00, 8'(a / 100 + 2)}, 24'hFFFFFF);
    for (int a = 5800; a < 6000; a++) push(a, 24'h070020, 24'hFFFFFF);
    run(48'h0206, bc);
    chk("scroll_busy", bc, 32'd17601);
    @(negedge clk);
    chk("scroll_row0", {8'd0, mem[0]}, 32'h070002);
    chk("scroll_row57", {8'd0, mem[5799]}, 32'h07003B);
    chk("scroll_row59", {8'd0, mem[5999]}, 32'h070020);

    // FILL clipped at the bottom-right corner.
    for (int y = 58; y < 60; y++)
      for (int x = 95; x < 100; x++) push(y * 100 + x, 24'h07002A, 24'hFFFFFF);
    run(48'h2A05_0A3A_5F07, bc);
    chk("fill_busy", bc, 32'd11);
    run(48'h2A05_003A_5F07, bc);
    chk("fill_w0_busy", bc, 32'd1);
    run(48'h0006, bc);
    chk("scroll_n0_busy", bc, 32'd1);
    run(48'h0009, bc);
    chk("unknown_op_busy", bc, 32'd0);

    // Reset in the middle of a CLEAR.
    for (int i = 0; i <= 300; i++) push(i, 24'h070020, 24'hFFFFFF);
    send(48'h01);
    n = 0;
    while (!(video_write === 1'b1 && video_address == 16'd300) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("clear_reached_300", {31'd0, (n < 2000)}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_write", {31'd0, video_write}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    #1 reset = 1'b0;
    push(0, 24'h070045, 24'hFFFFFF);
    run(48'h4502, bc);
    chk("accept_after_reset", {31'd0, (bc > 0)}, 32'd1);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
